// File: rtl/victim_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cache_pkg                                                    |
// | Description : Shared types, FSM encoding and address-split helpers for     |
// |               the victim write-back path.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cache_pkg;

  localparam int IDX_WID_DEF  = 10;
  localparam int WORD_WID_DEF = 64;

  typedef logic [IDX_WID_DEF-1:0]  idx_t;
  typedef logic [WORD_WID_DEF-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    SEND   = 3'd2,
    FETCH  = 3'd3,
    CLEAN  = 3'd4
  } wb_state_e;

  // Byte-offset bits covered by one cache line.
  function automatic int off_wid(input int line_words, input int word_wid);
    return $clog2(line_words * word_wid / 8);
  endfunction

  // Tag bits left over once index and line offset are removed from the address.
  function automatic int tag_wid(input int addr_wid, input int idx_wid,
                                 input int line_words, input int word_wid);
    return addr_wid - idx_wid - off_wid(line_words, word_wid);
  endfunction

endpackage
`default_nettype wire

// File: rtl/victim_writeback_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : victim_fifo                                                  |
// | Description : Small synchronous FIFO holding pending victim line indices.  |
// |               A push into a full FIFO succeeds only when a pop happens in  |
// |               the same cycle; otherwise it is dropped and flagged.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module victim_fifo #(
  parameter int DEPTH = 4,
  parameter int WID   = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [WID-1:0] wdata,
  output logic [WID-1:0] rdata,
  output logic           full,
  output logic           empty,
  output logic           drop
);

  localparam int PTR_WID = $clog2(DEPTH);

  logic [WID-1:0]   mem [DEPTH];
  logic [PTR_WID:0] wr_ptr;
  logic [PTR_WID:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the slot bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_WID] != rd_ptr[PTR_WID]) &&
                   (wr_ptr[PTR_WID-1:0] == rd_ptr[PTR_WID-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = mem[rd_ptr[PTR_WID-1:0]];

  // Pointer update; storage has no reset since empty masks stale entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry write; on full+pop the freed slot is the one being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_WID-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/victim_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : victim_writeback                                             |
// | Description : Queues eviction candidates from the LRU tracker, looks each  |
// |               one up in the cache array and streams dirty lines to memory  |
// |               as a LINE_WORDS-beat burst, then clears the dirty bit.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module victim_writeback
  import cache_pkg::*;
#(
  parameter  int WORD_WID   = 64,
  parameter  int LINE_WORDS = 4,
  parameter  int IDX_WID    = 10,
  parameter  int ADDR_WID   = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int OFF_WID    = off_wid(LINE_WORDS, WORD_WID),
  localparam int TAG_WID    = tag_wid(ADDR_WID, IDX_WID, LINE_WORDS, WORD_WID),
  localparam int BEAT_WID   = $clog2(LINE_WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                victim_valid_i,
  input  logic [IDX_WID-1:0]  victim_idx_i,
  output logic                rd_en_o,
  output logic [IDX_WID-1:0]  rd_idx_o,
  output logic [BEAT_WID-1:0] rd_word_o,
  input  logic [WORD_WID-1:0] rd_data_i,
  input  logic [TAG_WID-1:0]  rd_tag_i,
  input  logic                rd_dirty_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_WID-1:0] mem_addr_o,
  output logic [WORD_WID-1:0] mem_data_o,
  output logic                mem_last_o,
  output logic                clr_dirty_o,
  output logic [IDX_WID-1:0]  clr_idx_o,
  output logic                busy_o,
  output logic                overflow_o
);

  localparam logic [BEAT_WID-1:0] LAST_BEAT = BEAT_WID'(LINE_WORDS - 1);

  wb_state_e           state;
  wb_state_e           next_state;
  logic [BEAT_WID-1:0] beat;
  logic [IDX_WID-1:0]  cur_idx;
  logic [ADDR_WID-1:0] line_addr;
  logic [WORD_WID-1:0] beat_data;
  logic                overflow;

  logic                fifo_pop;
  logic [IDX_WID-1:0]  fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_drop;

  victim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WID   (IDX_WID)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (victim_valid_i),
    .pop   (fifo_pop),
    .wdata (victim_idx_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // A victim can only be lost while the queue is full.
  a_drop_only_when_full : assert property (
    @(posedge clk_i) disable iff (rst_i) fifo_drop |-> fifo_full
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Next state plus all strobes decoded from state and beat.
  always_comb begin
    next_state  = state;
    fifo_pop    = 1'b0;
    rd_en_o     = 1'b0;
    rd_idx_o    = '0;
    rd_word_o   = '0;
    mem_valid_o = 1'b0;
    mem_last_o  = 1'b0;
    clr_dirty_o = 1'b0;
    clr_idx_o   = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          rd_en_o    = 1'b1;
          rd_idx_o   = fifo_head;
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        next_state = rd_dirty_i ? SEND : IDLE;
      end
      SEND: begin
        mem_valid_o = 1'b1;
        mem_last_o  = (beat == LAST_BEAT);
        if (mem_ready_i) begin
          if (beat == LAST_BEAT) begin
            next_state = CLEAN;
          end else begin
            // Fetch the next word only after the current one is accepted.
            rd_en_o    = 1'b1;
            rd_idx_o   = cur_idx;
            rd_word_o  = beat + BEAT_WID'(1);
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        next_state = SEND;
      end
      CLEAN: begin
        clr_dirty_o = 1'b1;
        clr_idx_o   = cur_idx;
        next_state  = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Line index, burst address, beat data and beat counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_idx   <= '0;
      line_addr <= '0;
      beat_data <= '0;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) cur_idx <= fifo_head;
        end
        LOOKUP: begin
          beat <= '0;
          if (rd_dirty_i) begin
            line_addr <= {rd_tag_i, cur_idx, {OFF_WID{1'b0}}};
            beat_data <= rd_data_i;
          end
        end
        FETCH: begin
          beat_data <= rd_data_i;
          beat      <= beat + BEAT_WID'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky record of any victim lost to a full queue.
  always_ff @(posedge clk_i) begin
    if (rst_i)          overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

  assign mem_addr_o = line_addr;
  assign mem_data_o = beat_data;
  assign overflow_o = overflow;
  assign busy_o     = (state != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_victim_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_victim_writeback                                          |
// | Description : Directed self-checking bench for victim_writeback with a     |
// |               behavioural cache array (tag/data/dirty) model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_victim_writeback;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        victim_valid_i;
  logic [9:0]  victim_idx_i;
  logic        rd_en_o;
  logic [9:0]  rd_idx_o;
  logic [1:0]  rd_word_o;
  logic [63:0] rd_data_i  = '0;
  logic [16:0] rd_tag_i   = '0;
  logic        rd_dirty_i = 1'b0;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_data_o;
  logic        mem_last_o;
  logic        clr_dirty_o;
  logic [9:0]  clr_idx_o;
  logic        busy_o;
  logic        overflow_o;

  victim_writeback dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .victim_valid_i (victim_valid_i),
    .victim_idx_i   (victim_idx_i),
    .rd_en_o        (rd_en_o),
    .rd_idx_o       (rd_idx_o),
    .rd_word_o      (rd_word_o),
    .rd_data_i      (rd_data_i),
    .rd_tag_i       (rd_tag_i),
    .rd_dirty_i     (rd_dirty_i),
    .mem_valid_o    (mem_valid_o),
    .mem_ready_i    (mem_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_last_o     (mem_last_o),
    .clr_dirty_o    (clr_dirty_o),
    .clr_idx_o      (clr_idx_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cache contents: line 0x00A carries the hand-picked tag/data, others a pattern.
  function automatic logic [16:0] tag_of(input logic [9:0] idx);
    return (idx == 10'h00A) ? 17'h1ABCD : 17'h00100 + 17'(idx);
  endfunction

  function automatic logic [63:0] word_of(input logic [9:0] idx, input logic [1:0] w);
    logic [3:0] nib;
    nib = 4'(w) + 4'd1;
    if (idx == 10'h00A) return {16{nib}};
    return 64'hF00D_0000_0000_0000 | (64'(idx) << 32) | 64'(w);
  endfunction

  function automatic logic [31:0] addr_of(input logic [9:0] idx);
    return {tag_of(idx), idx, 5'b0};
  endfunction

  // Cache array model: one-cycle read latency, dirty lines are idx >= 8 after reset.
  logic dirty_mem [1024];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 1024; i++) dirty_mem[i] <= (i >= 8);
    end else if (clr_dirty_o) begin
      dirty_mem[clr_idx_o] <= 1'b0;
    end
    if (rd_en_o) begin
      rd_data_i  <= word_of(rd_idx_o, rd_word_o);
      rd_tag_i   <= tag_of(rd_idx_o);
      rd_dirty_i <= dirty_mem[rd_idx_o];
    end
  end

  // Activity monitor: read strobes, accepted beats and dirty-clear pulses.
  int          rd_cnt   = 0;
  int          beat_cnt = 0;
  int          clr_cnt  = 0;
  logic [9:0]  last_clr_idx = '0;
  logic [31:0] cap_addr [$];
  logic [63:0] cap_data [$];
  logic        cap_last [$];
  always @(negedge clk) begin
    if (rd_en_o) rd_cnt++;
    if (mem_valid_o && mem_ready_i) begin
      beat_cnt++;
      cap_addr.push_back(mem_addr_o);
      cap_data.push_back(mem_data_o);
      cap_last.push_back(mem_last_o);
    end
    if (clr_dirty_o) begin
      clr_cnt++;
      last_clr_idx = clr_idx_o;
    end
  end

  task automatic push(input logic [9:0] idx);
    victim_valid_i = 1'b1;
    victim_idx_i   = idx;
    @(posedge clk);
    #1 victim_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) chk("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  task automatic wait_beats(input int target, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (beat_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (beat_cnt < target) chk("beat_timeout", 64'(beat_cnt), 64'(target));
  endtask

  // Compare the four beats captured from index b0 against the line model.
  task automatic chk_burst(input string tag, input int b0, input logic [9:0] idx);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, 64'(cap_addr[b0+i]), 64'(addr_of(idx)));
      chk({tag, "_data"}, cap_data[b0+i], word_of(idx, 2'(i)));
      chk({tag, "_last"}, 64'(cap_last[b0+i]), 64'(i == 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r0, b0, c0;
    logic [63:0] exp_words [4];
    exp_words[0] = 64'h1111_1111_1111_1111;
    exp_words[1] = 64'h2222_2222_2222_2222;
    exp_words[2] = 64'h3333_3333_3333_3333;
    exp_words[3] = 64'h4444_4444_4444_4444;

    rst_i = 1'b1; victim_valid_i = 1'b0; victim_idx_i = '0; mem_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rd_en",    64'(rd_en_o),     64'd0);
    chk("rst_valid",    64'(mem_valid_o), 64'd0);
    chk("rst_last",     64'(mem_last_o),  64'd0);
    chk("rst_clr",      64'(clr_dirty_o), 64'd0);
    chk("rst_busy",     64'(busy_o),      64'd0);
    chk("rst_overflow", 64'(overflow_o),  64'd0);
    chk("rst_addr",     64'(mem_addr_o),  64'd0);
    chk("rst_data",     mem_data_o,       64'd0);

    // 1. Clean victim: one lookup, no traffic, idle after two cycles
    r0 = rd_cnt; b0 = beat_cnt; c0 = clr_cnt;
    push(10'h005);
    @(negedge clk);
    chk("clean_busy_hi", 64'(busy_o), 64'd1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("clean_busy_lo", 64'(busy_o), 64'd0);
    chk("clean_rd",      64'(rd_cnt - r0),   64'd1);
    chk("clean_beats",   64'(beat_cnt - b0), 64'd0);
    chk("clean_clr",     64'(clr_cnt - c0),  64'd0);

    // 2. Dirty victim with memory always ready
    @(posedge clk); #1 mem_ready_i = 1'b1;
    r0 = rd_cnt; b0 = beat_cnt; c0 = clr_cnt;
    push(10'h00A);
    wait_idle(100);
    chk("dirty_beats", 64'(beat_cnt - b0), 64'd4);
    chk("dirty_rd",    64'(rd_cnt - r0),   64'd4);
    chk("dirty_clr",   64'(clr_cnt - c0),  64'd1);
    chk("dirty_clr_idx", 64'(last_clr_idx), 64'h00A);
    for (int i = 0; i < 4; i++) begin
      chk("dirty_addr", 64'(cap_addr[b0+i]), 64'hD5E6_8140);
      chk("dirty_data", cap_data[b0+i], exp_words[i]);
      chk("dirty_last", 64'(cap_last[b0+i]), 64'(i == 3));
    end

    // 3. Backpressure for 5 cycles while the second beat is presented
    r0 = rd_cnt; b0 = beat_cnt; c0 = clr_cnt;
    push(10'h00B);
    wait_beats(b0 + 1, 50);
    @(posedge clk); #1 mem_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid", 64'(mem_valid_o), 64'd1);
    chk("bp_addr",  64'(mem_addr_o),  64'(addr_of(10'h00B)));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(mem_valid_o), 64'd1);
      chk("bp_hold_addr",  64'(mem_addr_o),  64'(addr_of(10'h00B)));
      chk("bp_hold_data",  mem_data_o,       word_of(10'h00B, 2'd1));
      chk("bp_hold_last",  64'(mem_last_o),  64'd0);
      chk("bp_hold_rd_en", 64'(rd_en_o),     64'd0);
    end
    @(posedge clk); #1 mem_ready_i = 1'b1;
    wait_idle(100);
    chk("bp_beats",   64'(beat_cnt - b0), 64'd4);
    chk("bp_rd",      64'(rd_cnt - r0),   64'd4);
    chk("bp_clr",     64'(clr_cnt - c0),  64'd1);
    chk("bp_clr_idx", 64'(last_clr_idx),  64'h00B);
    chk_burst("bp", b0, 10'h00B);

    // 4. Overflow: memory stalled, six back-to-back victims, sixth is dropped
    @(posedge clk); #1 mem_ready_i = 1'b0;
    r0 = rd_cnt; b0 = beat_cnt; c0 = clr_cnt;
    for (int i = 0; i < 5; i++) push(10'h020 + 10'(i));
    chk("ovf_not_yet", 64'(overflow_o), 64'd0);
    push(10'h025);
    @(negedge clk);
    chk("ovf_set",  64'(overflow_o), 64'd1);
    chk("ovf_busy", 64'(busy_o),     64'd1);
    @(posedge clk); #1 mem_ready_i = 1'b1;
    wait_idle(400);
    chk("ovf_beats",    64'(beat_cnt - b0), 64'd20);
    chk("ovf_rd",       64'(rd_cnt - r0),   64'd20);
    chk("ovf_clr",      64'(clr_cnt - c0),  64'd5);
    chk("ovf_last_idx", 64'(last_clr_idx),  64'h024);
    chk("ovf_sticky",   64'(overflow_o),    64'd1);
    chk_burst("ovf_first", b0, 10'h020);
    chk_burst("ovf_fifth", b0 + 16, 10'h024);

    // 5. Reset after the first beat abandons the burst
    b0 = beat_cnt; c0 = clr_cnt;
    push(10'h00C);
    wait_beats(b0 + 1, 50);
    @(posedge clk); #1 rst_i = 1'b1; mem_ready_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("mrst_valid",    64'(mem_valid_o), 64'd0);
    chk("mrst_busy",     64'(busy_o),      64'd0);
    chk("mrst_overflow", 64'(overflow_o),  64'd0);
    chk("mrst_addr",     64'(mem_addr_o),  64'd0);
    repeat (5) @(negedge clk);
    chk("mrst_clr",   64'(clr_cnt - c0),  64'd0);
    chk("mrst_beats", 64'(beat_cnt - b0), 64'd1);
    chk("mrst_idle",  64'(mem_valid_o),   64'd0);

    // 6. Duplicate victim: second copy finds the line clean
    @(posedge clk); #1 mem_ready_i = 1'b1;
    r0 = rd_cnt; b0 = beat_cnt; c0 = clr_cnt;
    push(10'h00A);
    push(10'h00A);
    wait_idle(100);
    chk("dup_beats",   64'(beat_cnt - b0), 64'd4);
    chk("dup_clr",     64'(clr_cnt - c0),  64'd1);
    chk("dup_rd",      64'(rd_cnt - r0),   64'd5);
    chk("dup_clr_idx", 64'(last_clr_idx),  64'h00A);
    chk("dup_data3",   cap_data[b0+3],     exp_words[3]);
    chk("dup_overflow", 64'(overflow_o),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
